grant_burst_ctrl: RTL and testbench

//  Downstream consumer of the arbiter FSM's grant level (GRANT state output).

---
 rtl/grant_burst_pkg.sv | 16 +
 rtl/grant_burst_ctrl_hs_pipe_reg.sv | 50 +++++
 rtl/grant_burst_ctrl.sv | 154 +++++++++++++++
 tb/tb_grant_burst_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/grant_burst_pkg.sv
// Shared types and default parameters for the grant-driven burst controller.
package grant_burst_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_XFER      = 3'd1,
      ST_DRAIN     = 3'd2,
      ST_REVOKE    = 3'd3,
      ST_WAIT_DROP = 3'd4
   } ty_GRANT_BURST_STATE;

   localparam int DEF_DATA_W         = 32;
   localparam int DEF_LEN_W          = 8;
   localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/grant_burst_ctrl_hs_pipe_reg.sv
// Single valid/ready register stage; a load and an unload may happen in the
// same cycle, so it sustains one beat per cycle.
module hs_pipe_reg
   import grant_burst_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_ck,
   input  logic              i_arst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              valid_q;
   logic              valid_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // Next-state of the stage; the caller only loads when the stage is empty or draining.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (i_load) begin
         valid_d = 1'b1;
         data_d  = i_data;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Stage register.
   always_ff @(posedge i_ck or negedge i_arst_n) begin
      if (!i_arst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;

endmodule

// File: rtl/grant_burst_ctrl.sv
// Moves one burst per grant from source to sink through a register stage and
// pulses o_revoke once the burst has drained or the source went quiet.
module grant_burst_ctrl
   import grant_burst_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int LEN_W          = DEF_LEN_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              i_ck,
   input  logic              i_arst_n,
   input  logic              i_grant,
   input  logic [LEN_W-1:0]  i_burstLen,
   input  logic              i_srcValid,
   input  logic [DATA_W-1:0] i_srcData,
   output logic              o_srcReady,
   output logic              o_dstValid,
   output logic [DATA_W-1:0] o_dstData,
   input  logic              i_dstReady,
   output logic              o_revoke,
   output logic              o_timeout,
   output logic [LEN_W-1:0]  o_beatCount
);

   localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_ONE = {{(IDLE_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   ty_GRANT_BURST_STATE state_q, state_d;
   logic                grant_q;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic                timeout_q, timeout_d;
   logic                revoke_q;
   logic                src_ready_s;
   logic                src_fire_s;
   logic                dst_valid_s;
   logic [DATA_W-1:0]   dst_data_s;
   logic [LEN_W-1:0]    cnt_inc_s;

   assign cnt_inc_s = cnt_q + CNT_ONE;

   // Next-state, counters and source-ready decode.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      idle_d      = idle_q;
      timeout_d   = timeout_q;
      src_ready_s = 1'b0;
      src_fire_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_grant && !grant_q) begin
               len_d     = i_burstLen;
               cnt_d     = '0;
               idle_d    = '0;
               timeout_d = 1'b0;
               state_d   = ST_XFER;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_XFER: begin
            src_ready_s = i_grant && (cnt_q < len_q) && (!dst_valid_s || i_dstReady);
            src_fire_s  = src_ready_s && i_srcValid;
            if (!i_grant) begin
               state_d = ST_IDLE;
            end else if (len_q == '0) begin
               state_d = ST_REVOKE;
            end else if (src_fire_s) begin
               cnt_d  = cnt_inc_s;
               idle_d = '0;
               if (cnt_inc_s == len_q) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_XFER;
               end
            end else if (idle_q == IDLE_LIM) begin
               timeout_d = 1'b1;
               idle_d    = '0;
               state_d   = ST_DRAIN;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
         end
         ST_DRAIN: begin
            if (!i_grant) begin
               state_d = ST_IDLE;
            end else if (!dst_valid_s || i_dstReady) begin
               state_d = ST_REVOKE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_REVOKE: begin
            state_d = ST_WAIT_DROP;
         end
         ST_WAIT_DROP: begin
            if (!i_grant) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DROP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers; o_revoke is registered off the REVOKE entry.
   always_ff @(posedge i_ck or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         idle_q    <= '0;
         timeout_q <= 1'b0;
         revoke_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= i_grant;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
         revoke_q  <= (state_d == ST_REVOKE);
      end
   end

   hs_pipe_reg #(
      .DATA_W (DATA_W)
   ) u_pipe (
      .i_ck     (i_ck),
      .i_arst_n (i_arst_n),
      .i_load   (src_fire_s),
      .i_data   (i_srcData),
      .i_ready  (i_dstReady),
      .o_valid  (dst_valid_s),
      .o_data   (dst_data_s)
   );

   assign o_srcReady  = src_ready_s;
   assign o_dstValid  = dst_valid_s;
   assign o_dstData   = dst_data_s;
   assign o_revoke    = revoke_q;
   assign o_timeout   = timeout_q;
   assign o_beatCount = cnt_q;

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Self-checking bench for grant_burst_ctrl: burst table plus hand-written
// grant-drop and reset sequences, with a data scoreboard on the sink side.
module tb_grant_burst_ctrl;

   localparam int          DATA_W = 32;
   localparam int          LEN_W  = 8;
   localparam int          TO_CYC = 16;
   localparam logic [31:0] DBASE  = 32'hA5C3_0000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_grant = 1'b0;
   logic [LEN_W-1:0]  i_burstLen = '0;
   logic              i_srcValid = 1'b0;
   logic [DATA_W-1:0] i_srcData = '0;
   logic              i_dstReady = 1'b0;
   logic              o_srcReady;
   logic              o_dstValid;
   logic [DATA_W-1:0] o_dstData;
   logic              o_revoke;
   logic              o_timeout;
   logic [LEN_W-1:0]  o_beatCount;

   always #5 clk = ~clk;

   grant_burst_ctrl #(
      .DATA_W         (DATA_W),
      .LEN_W          (LEN_W),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .i_ck        (clk),
      .i_arst_n    (rst_n),
      .i_grant     (i_grant),
      .i_burstLen  (i_burstLen),
      .i_srcValid  (i_srcValid),
      .i_srcData   (i_srcData),
      .o_srcReady  (o_srcReady),
      .o_dstValid  (o_dstValid),
      .o_dstData   (o_dstData),
      .i_dstReady  (i_dstReady),
      .o_revoke    (o_revoke),
      .o_timeout   (o_timeout),
      .o_beatCount (o_beatCount)
   );

   typedef struct {
      int len;
      int nsrc;
      int st0;
      int stn;
      int exp_rev;
      int exp_to;
      int exp_cnt;
   } vec_t;

   vec_t              vecs[7];
   int                checks = 0;
   int                errors = 0;
   logic [DATA_W-1:0] exp_q[$];
   int                seq = 0;
   int                burst_acc = 0;
   int                beats_out = 0;
   int                rev_total = 0;
   bit                p_hold = 1'b0;
   logic [DATA_W-1:0] p_data = '0;
   bit                s_rev = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock cycle: drive inputs after the edge, sample mid-cycle, run the scoreboard.
   task automatic step(input bit g, input bit sv, input bit dr);
      logic [DATA_W-1:0] e;
      @(posedge clk);
      #1;
      i_grant    = g;
      i_srcValid = sv;
      i_srcData  = DBASE + 32'(seq);
      i_dstReady = dr;
      #1;
      if (p_hold) begin
         chk("hold_valid", o_dstValid, 1);
         chk("hold_data", o_dstData, p_data);
      end
      if (o_dstValid && !dr) chk("ready_blocked", o_srcReady, 0);
      if (sv && o_srcReady) begin
         exp_q.push_back(i_srcData);
         seq++;
         burst_acc++;
      end
      if (o_dstValid && dr) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", o_dstData, -1);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", o_dstData, e);
         end
         beats_out++;
      end
      p_hold = o_dstValid && !dr;
      p_data = o_dstData;
      s_rev  = o_revoke;
      if (o_revoke) rev_total++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic burst(input string nm, input int len, input int nsrc, input int st0,
                        input int stn, input int exp_rev, input int exp_to,
                        input int exp_cnt, input int rel0);
      int rev_rel = -1;
      int rev_n   = 0;
      int to_r    = 0;
      int cnt_r   = 0;
      int after   = 0;
      bit sv;
      bit dr;
      i_burstLen = LEN_W'(len);
      burst_acc  = 0;
      beats_out  = 0;
      for (int rel = rel0; rel < 400 && after < 5; rel++) begin
         sv = (burst_acc < nsrc);
         dr = !((rel >= st0) && (rel < st0 + stn));
         step(1'b1, sv, dr);
         if (rel == 1) begin
            chk({nm, "_to_clr"}, o_timeout, 0);
            chk({nm, "_cnt_clr"}, o_beatCount, 0);
         end
         if (s_rev) begin
            rev_n++;
            if (rev_rel < 0) begin
               rev_rel = rel;
               to_r    = int'(o_timeout);
               cnt_r   = int'(o_beatCount);
            end
         end
         if (rev_rel >= 0) after++;
      end
      chk({nm, "_revoke_cycle"}, rev_rel, exp_rev);
      chk({nm, "_revoke_pulses"}, rev_n, 1);
      chk({nm, "_timeout"}, to_r, exp_to);
      chk({nm, "_beatcount"}, cnt_r, exp_cnt);
      chk({nm, "_src_accepts"}, burst_acc, exp_cnt);
      chk({nm, "_delivered"}, beats_out, exp_cnt);
      chk({nm, "_sb_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int r0;
      // len, nsrc, stall start, stall length, revoke cycle, timeout, beats
      vecs[0] = '{4,   4, 0, 0, 6,   0, 4};
      vecs[1] = '{3,   3, 3, 5, 10,  0, 3};
      vecs[2] = '{8,   2, 0, 0, 20,  1, 2};
      vecs[3] = '{0,   3, 0, 0, 2,   0, 0};
      vecs[4] = '{1,   1, 0, 0, 3,   0, 1};
      vecs[5] = '{5,   5, 0, 0, 7,   0, 5};
      vecs[6] = '{255, 255, 0, 0, 257, 0, 255};

      repeat (2) @(posedge clk);
      #2;
      chk("rst_srcReady", o_srcReady, 0);
      chk("rst_dstValid", o_dstValid, 0);
      chk("rst_dstData", o_dstData, 0);
      chk("rst_revoke", o_revoke, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_beatCount", o_beatCount, 0);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 7; i++) begin
         burst($sformatf("vec%0d", i), vecs[i].len, vecs[i].nsrc, vecs[i].st0, vecs[i].stn,
               vecs[i].exp_rev, vecs[i].exp_to, vecs[i].exp_cnt, 0);
         idle(3);
      end

      // Grant dropped after two beats with the second beat stuck in the stage.
      r0         = rev_total;
      i_burstLen = 8'd6;
      burst_acc  = 0;
      beats_out  = 0;
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      chk("drop_srcReady", o_srcReady, 0);
      chk("drop_pending", o_dstValid, 1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("drop_src_accepts", burst_acc, 2);
      chk("drop_delivered", beats_out, 2);
      chk("drop_sb_empty", exp_q.size(), 0);
      chk("drop_no_revoke", rev_total - r0, 0);
      chk("drop_dstValid_clear", o_dstValid, 0);
      burst("regrant", 3, 3, 0, 0, 5, 0, 3, 0);
      idle(3);

      // Asynchronous reset in the middle of a burst, grant held high throughout.
      i_burstLen = 8'd6;
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_srcReady", o_srcReady, 0);
      chk("arst_dstValid", o_dstValid, 0);
      chk("arst_dstData", o_dstData, 0);
      chk("arst_revoke", o_revoke, 0);
      chk("arst_timeout", o_timeout, 0);
      chk("arst_beatCount", o_beatCount, 0);
      exp_q.delete();
      p_hold     = 1'b0;
      i_burstLen = 8'd2;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      burst("post_rst", 2, 2, 0, 0, 4, 0, 2, 1);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
